// File: rtl/event_stream_arbiter_pkg.sv
// Shared readout definitions for the event stream arbiter: word-type field,
// type codes, FSM state encoding and the abort word layout.
package event_stream_arbiter_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned TYPE_HI = 63;
  localparam int unsigned TYPE_LO = 60;
  localparam int unsigned TYPE_W  = TYPE_HI - TYPE_LO + 1;
  localparam int unsigned SRC_W   = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [TYPE_W-1:0] TYPE_BOD   = 4'd2;
  localparam logic [TYPE_W-1:0] TYPE_ABORT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Marker word written downstream when an event is abandoned on timeout
  typedef struct packed {
    logic [TYPE_W-1:0]                 wtype;
    logic [SRC_W-1:0]                  src;
    logic [WORD_W-TYPE_W-SRC_W-1:0]    pad;
  } abort_word_t;

  function automatic logic [WORD_W-1:0] abort_word(input logic [SRC_W-1:0] src);
    abort_word_t w;
    w.wtype = TYPE_ABORT;
    w.src   = src;
    w.pad   = '0;
    return w;
  endfunction

endpackage

// File: rtl/event_stream_arbiter_picker.sv
// Round-robin picker: first requester strictly after last_ptr, wrapping.
module rr_priority_picker #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N-1:0]     grant_c,
  output logic             found_c
);

  // Two passes: indices above the pointer first, then the wrapped range.
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_c && req[i] && (32'(i) > 32'(last_ptr))) begin
        grant_c[i] = 1'b1;
        found_c    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found_c && req[i] && (32'(i) <= 32'(last_ptr))) begin
        grant_c[i] = 1'b1;
        found_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_stream_arbiter.sv
// Event-granular round-robin arbiter: one source owns the output until its
// last word is accepted or a mid-event stall times out into an abort word.
module event_stream_arbiter
  import event_stream_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [WORD_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      fifo_full,
  output logic [WORD_W-1:0]         data_out,
  output logic                      wr_en_out,
  output logic [CNT_W-1:0]          abort_count
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [WORD_W-1:0]  data_d;
  logic               wr_en_d;
  logic [CNT_W-1:0]   abort_d;

  logic [NUM_SRC-1:0] pick_grant_c;
  logic               pick_found_c;
  logic [PTR_W-1:0]   pick_idx;
  logic [WORD_W-1:0]  sel_word;
  logic               sel_valid;
  logic               sel_last;

  rr_priority_picker #(.N(NUM_SRC)) u_picker (
    .req      (src_valid & src_mask),
    .last_ptr (last_q),
    .grant_c  (pick_grant_c),
    .found_c  (pick_found_c)
  );

  // One-hot grant to index
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick_grant_c[i]) pick_idx = PTR_W'(i);
    end
  end

  assign sel_word  = src_data[32'(grant_q)*WORD_W +: WORD_W];
  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, datapath next values and the handshake towards the sources
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    stall_d   = stall_q;
    data_d    = data_out;
    wr_en_d   = 1'b0;
    abort_d   = abort_count;
    src_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && pick_found_c) begin
          grant_d = pick_idx;
          stall_d = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        src_ready[grant_q] = !fifo_full;
        if (sel_valid && !fifo_full) begin
          // Zero words are consumed silently; downstream reads zero as empty
          data_d  = sel_word;
          wr_en_d = (sel_word != '0);
          stall_d = '0;
          if (sel_last) begin
            last_d  = grant_q;
            state_d = ST_IDLE;
          end
        end else if (!sel_valid && !fifo_full) begin
          if (stall_q == STALL_LIMIT) begin
            stall_d = '0;
            state_d = ST_ABORT;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (!fifo_full) begin
          data_d  = abort_word(SRC_W'(grant_q));
          wr_en_d = 1'b1;
          if (abort_count != '1) abort_d = abort_count + 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers; last pointer resets to the top so source 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q     <= '0;
      last_q      <= PTR_W'(NUM_SRC - 1);
      stall_q     <= '0;
      data_out    <= '0;
      wr_en_out   <= 1'b0;
      abort_count <= '0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      stall_q     <= stall_d;
      data_out    <= data_d;
      wr_en_out   <= wr_en_d;
      abort_count <= abort_d;
    end
  end

endmodule

// File: doc/event_stream_arbiter.md
EVENT_STREAM_ARBITER -- requirements
Module: event_stream_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of event sources (2..8).
REQ-002 Parameter TIMEOUT, default 255: mid-event stall limit in clock cycles (1..65535).
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits new grants; low = finish current event, then hold idle.
REQ-006 src_mask  input  NUM_SRC  per-source participation enable.
REQ-007 src_data  input  64*NUM_SRC  packed source words; source i occupies [64*i+63:64*i].
REQ-008 src_valid  input  NUM_SRC  source word available.
REQ-009 src_last  input  NUM_SRC  current word is the final word of an event.
REQ-010 src_ready  output  NUM_SRC  one-hot or zero; word accepted when valid&ready.
REQ-011 fifo_full  input  1  downstream full/backpressure.
REQ-012 data_out  output  64  registered output word.
REQ-013 wr_en_out  output  1  data_out valid for one cycle.
REQ-014 abort_count  output  16  saturating count of timeout aborts.

Function
REQ-015 States SHALL be IDLE, GRANT, ABORT.
- IDLE: if enable and any (src_valid & src_mask), grant the first such source after last_grant in round-robin order; go to GRANT next cycle.
- IDLE: no src_ready asserted.
REQ-016 In GRANT, src_ready[g] SHALL equal !fifo_full; all other src_ready bits 0.
REQ-017 An accepted word SHALL appear on data_out with wr_en_out=1 exactly one cycle after acceptance (latency 1).
REQ-018 An accepted word equal to 64'd0 SHALL be consumed but not written (wr_en_out stays 0); downstream treats zero as empty.
REQ-019 Acceptance with src_last[g]=1 SHALL return to IDLE and set last_grant=g.
- Consequence: no interleaving of sources within an event.
REQ-020 In GRANT, stall counter SHALL increment each cycle with src_valid[g]=0 and fifo_full=0, clear on every accepted word, and never count fifo_full cycles.
REQ-021 Stall counter reaching TIMEOUT SHALL enter ABORT.
REQ-022 ABORT SHALL write one word {4'hF, 4'(g), 56'd0} when fifo_full=0, then increment abort_count (saturate at 16'hFFFF), set last_grant=g, and return to IDLE.
REQ-023 enable or src_mask changes SHALL NOT affect an event already in GRANT.
REQ-024 Source deasserting src_valid mid-event SHALL keep the grant (only timeout releases it).
REQ-025 Single eligible source SHALL be re-granted back-to-back with one IDLE cycle between events.
REQ-026 src_last on a timeout-boundary cycle: acceptance takes priority over abort.

Reset
REQ-027 Reset SHALL force IDLE, src_ready=0, data_out=64'd0, wr_en_out=0, abort_count=0, stall counter=0, last_grant=NUM_SRC-1 (source 0 first).
REQ-028 Reset mid-event SHALL discard the partial event with no abort word emitted.

Structure
REQ-029 Shared readout package SHALL hold: word-type field position [63:60], BoD type 4'd2, abort type 4'hF, state encoding.
REQ-030 Sub-module rr_priority_picker (mask + last pointer -> one-hot grant, found flag) SHALL be used.
- All other logic stays in event_stream_arbiter.

Verification
REQ-031 Src0 and src2 valid with 3-word events, last_grant=3 -> src0 words then src2 words, wr_en_out high 3 cycles each, one IDLE gap.
REQ-032 fifo_full held 10 cycles mid-event on src1 -> src_ready[1]=0 for those cycles, no abort, words resume in order.
REQ-033 Src3 stalls after first word with TIMEOUT=4 -> after 4 stall cycles, data_out=64'hF300000000000000, abort_count=1.
REQ-034 Event containing 64'd0 middle word -> only the two non-zero words written.
REQ-035 enable dropped during src1 event -> event completes; no further grant until enable=1.
REQ-036 reset asserted mid-event -> next cycle all outputs zero; first grant after reset goes to src0 when all valid.
